// File: rtl/econet_rx_frame_pkg.sv
// Shared constants, state encoding and CRC-16 (HDLC/X.25) byte step for the
// Econet receive path.
package econet_rx_frame_pkg;

  localparam logic [15:0] CRC_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC_POLY     = 16'h8408;
  localparam logic [15:0] CRC_RESIDUE  = 16'hF0B8;
  localparam logic [7:0]  BROADCAST_ID = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_CHECK,
    ST_DISCARD,
    ST_HOLD
  } state_t;

  // Reflected polynomial, data consumed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/econet_rx_frame_crc16.sv
// Byte-wide CRC-16 accumulator (module econet_crc16). clear reloads the init
// value; when clear and en coincide the byte is folded into the fresh value.
module econet_crc16
  import econet_rx_frame_pkg::*;
(
  input  logic        clk,
  input  logic        srst,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  logic [15:0] crc_reg;
  logic [15:0] crc_base;
  logic [15:0] crc_next;

  always_comb begin
    crc_base = clear ? CRC_INIT : crc_reg;
    crc_next = en ? crc16_byte(crc_base, data) : crc_base;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      crc_reg <= CRC_INIT;
    end else begin
      crc_reg <= crc_next;
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/econet_rx_frame.sv
// Econet receive front-end: buffers one frame, checks FCS/length, holds it for
// the host. Define ECONET_ADDR_FILTER_EN to drop frames not for this station.
module econet_rx_frame
  import econet_rx_frame_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9,
  parameter int MIN_LEN    = 6,
  parameter int CNT_W      = 8
) (
  input  logic                  econet_clk,
  input  logic                  reset,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_byte_ready,
  input  logic                  rx_frame_start,
  input  logic                  rx_frame_end,
  input  logic [7:0]            station_id,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [7:0]            rd_data,
  output logic                  frame_ready,
  output logic [DEPTH_LOG2:0]   frame_len,
  input  logic                  frame_ack,
  output logic                  fcs_error,
  output logic                  overflow,
  output logic                  runt,
  output logic [CNT_W-1:0]      drop_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] MIN_CNT   = (DEPTH_LOG2+1)'(MIN_LEN);
  localparam logic [DEPTH_LOG2:0] CNT_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] CNT_TWO   = (DEPTH_LOG2+1)'(2);

  state_t                state_reg, state_next;
  logic [DEPTH_LOG2:0]   count_reg, count_next;
  logic [DEPTH_LOG2:0]   len_reg, len_next;
  logic                  ready_reg, ready_next;
  logic                  fcs_reg, fcs_next;
  logic                  ovf_reg, ovf_next;
  logic                  runt_reg, runt_next;
  logic [CNT_W-1:0]      drop_reg, drop_next;
  logic [7:0]            byte0_reg, byte0_next;
  logic [7:0]            rd_data_reg;
  logic                  crc_clear, crc_en, wr_en, open_frame;
  logic [DEPTH_LOG2-1:0] wr_addr;
  logic [15:0]           crc_value;
  logic [7:0]            mem [DEPTH];

`ifndef ECONET_ADDR_FILTER_EN
  logic unused_station;
  assign unused_station = ^station_id;
`endif

  econet_crc16 u_crc (
    .clk   (econet_clk),
    .srst  (reset),
    .clear (crc_clear),
    .en    (crc_en),
    .data  (rx_byte),
    .crc   (crc_value)
  );

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    len_next   = len_reg;
    ready_next = ready_reg;
    fcs_next   = fcs_reg;
    ovf_next   = ovf_reg;
    runt_next  = runt_reg;
    drop_next  = drop_reg;
    byte0_next = byte0_reg;
    crc_clear  = 1'b0;
    crc_en     = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = count_reg[DEPTH_LOG2-1:0];
    open_frame = 1'b0;

    unique case (state_reg)
      ST_IDLE, ST_DISCARD: begin
        if (rx_frame_start) begin
          open_frame = 1'b1;
          fcs_next   = 1'b0;
          ovf_next   = 1'b0;
          runt_next  = 1'b0;
        end else if (state_reg == ST_DISCARD && rx_frame_end) begin
          state_next = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (rx_frame_start) begin
          open_frame = 1'b1;
        end else if (rx_byte_ready && count_reg == DEPTH_CNT) begin
          ovf_next   = 1'b1;
          state_next = rx_frame_end ? ST_IDLE : ST_DISCARD;
        end else begin
          if (rx_byte_ready) begin
            wr_en      = 1'b1;
            crc_en     = 1'b1;
            count_next = count_reg + CNT_ONE;
          end
          if (rx_frame_end) begin
            state_next = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        state_next = ST_IDLE;
        if (count_reg < MIN_CNT) begin
          runt_next = 1'b1;
        end else if (crc_value != CRC_RESIDUE) begin
          fcs_next = 1'b1;
`ifdef ECONET_ADDR_FILTER_EN
        end else if (byte0_reg != station_id && byte0_reg != BROADCAST_ID) begin
          state_next = ST_IDLE;
`endif
        end else begin
          len_next   = count_reg - CNT_TWO;
          ready_next = 1'b1;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (rx_frame_start && drop_reg != '1) begin
          drop_next = drop_reg + CNT_W'(1);
        end
        if (frame_ack) begin
          ready_next = 1'b0;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // A start opens the frame; a byte arriving with it becomes byte 0.
    if (open_frame) begin
      state_next = ST_RECV;
      crc_clear  = 1'b1;
      count_next = '0;
      wr_addr    = '0;
      if (rx_byte_ready) begin
        wr_en      = 1'b1;
        crc_en     = 1'b1;
        count_next = CNT_ONE;
      end
    end
    if (wr_en && wr_addr == '0) begin
      byte0_next = rx_byte;
    end
  end

  always_ff @(posedge econet_clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      len_reg   <= '0;
      ready_reg <= 1'b0;
      fcs_reg   <= 1'b0;
      ovf_reg   <= 1'b0;
      runt_reg  <= 1'b0;
      drop_reg  <= '0;
      byte0_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      len_reg   <= len_next;
      ready_reg <= ready_next;
      fcs_reg   <= fcs_next;
      ovf_reg   <= ovf_next;
      runt_reg  <= runt_next;
      drop_reg  <= drop_next;
      byte0_reg <= byte0_next;
    end
  end

  // Frame buffer: plain array so it maps onto block RAM.
  always_ff @(posedge econet_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= rx_byte;
    end
  end

  always_ff @(posedge econet_clk) begin
    if (reset) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data     = rd_data_reg;
  assign frame_ready = ready_reg;
  assign frame_len   = len_reg;
  assign fcs_error   = fcs_reg;
  assign overflow    = ovf_reg;
  assign runt        = runt_reg;
  assign drop_count  = drop_reg;

endmodule

// File: tb/tb_econet_rx_frame.sv
// Scoreboard bench for econet_rx_frame (DEPTH_LOG2=4): predicted outcomes are
// queued as frames are sent and compared once the frame has been checked.
module tb_econet_rx_frame;

  localparam int DL2   = 4;
  localparam int DEPTH = 1 << DL2;
`ifdef ECONET_ADDR_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  logic           econet_clk = 1'b0;
  logic           reset = 1'b1;
  logic [7:0]     rx_byte = '0;
  logic           rx_byte_ready = 1'b0;
  logic           rx_frame_start = 1'b0;
  logic           rx_frame_end = 1'b0;
  logic [7:0]     station_id = 8'h05;
  logic [DL2-1:0] rd_addr = '0;
  logic [7:0]     rd_data;
  logic           frame_ready;
  logic [DL2:0]   frame_len;
  logic           frame_ack = 1'b0;
  logic           fcs_error, overflow, runt;
  logic [7:0]     drop_count;

  typedef struct {
    bit ready;
    int len;
    bit fcs;
    bit ovf;
    bit runt;
  } exp_t;

  exp_t       sb[$];
  exp_t       last_exp;
  logic [7:0] byte_q[$];
  logic [7:0] held_q[$];
  bit         holding = 1'b0;
  int         exp_drops = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  econet_rx_frame #(.DEPTH_LOG2(DL2), .MIN_LEN(6), .CNT_W(8)) dut (
    .econet_clk     (econet_clk),
    .reset          (reset),
    .rx_byte        (rx_byte),
    .rx_byte_ready  (rx_byte_ready),
    .rx_frame_start (rx_frame_start),
    .rx_frame_end   (rx_frame_end),
    .station_id     (station_id),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .frame_ready    (frame_ready),
    .frame_len      (frame_len),
    .frame_ack      (frame_ack),
    .fcs_error      (fcs_error),
    .overflow       (overflow),
    .runt           (runt),
    .drop_count     (drop_count)
  );

  always #5 econet_clk = ~econet_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  function automatic logic [15:0] crc_of();
    logic [15:0] c = 16'hFFFF;
    foreach (byte_q[i]) begin
      for (int b = 0; b < 8; b++) begin
        logic fb;
        fb = c[0] ^ byte_q[i][b];
        c = c >> 1;
        if (fb) c = c ^ 16'h8408;
      end
    end
    return c;
  endfunction

  task automatic make_good(input logic [7:0] b0, input int npay);
    logic [15:0] f;
    byte_q.delete();
    byte_q.push_back(b0);
    for (int i = 1; i < npay; i++) byte_q.push_back(8'($urandom_range(0, 255)));
    f = ~crc_of();
    byte_q.push_back(f[7:0]);
    byte_q.push_back(f[15:8]);
  endtask

  function automatic void predict();
    exp_t e;
    int   n;
    e = '{ready: 1'b0, len: 0, fcs: 1'b0, ovf: 1'b0, runt: 1'b0};
    n = byte_q.size();
    if (holding) begin
      e = last_exp;
      if (exp_drops < 255) exp_drops++;
    end else begin
      if (n > DEPTH) e.ovf = 1'b1;
      else if (n < 6) e.runt = 1'b1;
      else if (crc_of() != 16'hF0B8) e.fcs = 1'b1;
      else if (FILTER && byte_q[0] != station_id && byte_q[0] != 8'hFF) e.ready = 1'b0;
      else begin
        e.ready = 1'b1;
        e.len   = n - 2;
        held_q  = byte_q;
        holding = 1'b1;
      end
      last_exp = e;
    end
    sb.push_back(e);
  endfunction

  task automatic send_bytes(input bit with_start, input bit merge_start, input bit merge_end,
                            input bit with_end);
    int first;
    first = 0;
    @(negedge econet_clk);
    if (with_start) begin
      rx_frame_start = 1'b1;
      if (merge_start) begin
        rx_byte = byte_q[0];
        rx_byte_ready = 1'b1;
        first = 1;
      end
      @(negedge econet_clk);
      rx_frame_start = 1'b0;
      rx_byte_ready = 1'b0;
    end
    for (int i = first; i < byte_q.size(); i++) begin
      repeat ($urandom_range(0, 1)) @(negedge econet_clk);
      rx_byte = byte_q[i];
      rx_byte_ready = 1'b1;
      if (merge_end && with_end && i == byte_q.size() - 1) rx_frame_end = 1'b1;
      @(negedge econet_clk);
      rx_byte_ready = 1'b0;
      rx_frame_end = 1'b0;
    end
    if (with_end && !merge_end) begin
      rx_frame_end = 1'b1;
      @(negedge econet_clk);
      rx_frame_end = 1'b0;
    end
  endtask

  task automatic send_frame(input bit merge_start, input bit merge_end);
    predict();
    send_bytes(1'b1, merge_start, merge_end, 1'b1);
  endtask

  task automatic ack_frame();
    frame_ack = 1'b1;
    @(negedge econet_clk);
    frame_ack = 1'b0;
    @(negedge econet_clk);
    chk("ack_ready", frame_ready, 0);
    holding = 1'b0;
  endtask

  task automatic check_result(input string tag, input bit do_ack);
    exp_t e;
    e = sb.pop_front();
    for (int k = 0; k < 6 && !(frame_ready | fcs_error | overflow | runt); k++)
      @(negedge econet_clk);
    @(negedge econet_clk);
    chk({tag, "_ready"}, frame_ready, e.ready);
    chk({tag, "_fcs"}, fcs_error, e.fcs);
    chk({tag, "_ovf"}, overflow, e.ovf);
    chk({tag, "_runt"}, runt, e.runt);
    chk({tag, "_drops"}, drop_count, exp_drops);
    if (e.ready) begin
      chk({tag, "_len"}, frame_len, e.len);
      for (int a = 0; a < e.len + 2; a++) begin
        rd_addr = DL2'(a);
        @(negedge econet_clk);
        chk($sformatf("%s_data%0d", tag, a), rd_data, held_q[a]);
      end
    end
    if (do_ack) ack_frame();
  endtask

  initial begin
    repeat (3) @(negedge econet_clk);
    chk("rst_ready", frame_ready, 0);
    chk("rst_len", frame_len, 0);
    chk("rst_flags", {fcs_error, overflow, runt}, 0);
    chk("rst_drops", drop_count, 0);
    chk("rst_rdata", rd_data, 0);
    reset = 1'b0;

    byte_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h6E, 8'h90};
    send_frame(1'b0, 1'b0);
    check_result("t1_good", 1'b0);
    rd_addr = '0;
    @(negedge econet_clk);
    chk("t1_byte0", rd_data, 8'h31);
    ack_frame();

    byte_q[10] = 8'h91;
    send_frame(1'b0, 1'b0);
    check_result("t2_fcs", 1'b1);

    byte_q = '{8'h05, 8'h11, 8'h22};
    send_frame(1'b0, 1'b0);
    check_result("t3_runt", 1'b1);

    byte_q.delete();
    for (int i = 0; i < 17; i++) byte_q.push_back(8'(i + 8'h50));
    send_frame(1'b0, 1'b0);
    check_result("t4_ovf", 1'b1);
    make_good(8'h05, 10);
    send_frame(1'b0, 1'b0);
    check_result("t4_after", 1'b1);

    make_good(8'h05, 14);
    send_frame(1'b0, 1'b0);
    check_result("full", 1'b1);
    make_good(8'h05, 3);
    send_frame(1'b0, 1'b0);
    check_result("min_m1", 1'b1);
    make_good(8'h05, 4);
    send_frame(1'b1, 1'b1);
    check_result("min_merge", 1'b1);

    byte_q = '{8'hAA, 8'hBB};
    send_bytes(1'b1, 1'b0, 1'b0, 1'b0);
    make_good(8'hFF, 6);
    send_frame(1'b1, 1'b0);
    check_result("restart", 1'b1);

    make_good(8'h05, 8);
    send_frame(1'b0, 1'b0);
    check_result("t5_held", 1'b0);
    make_good(8'h05, 5);
    send_frame(1'b0, 1'b0);
    check_result("t5_drop1", 1'b0);
    make_good(8'hFF, 9);
    send_frame(1'b1, 1'b1);
    check_result("t5_drop2", 1'b1);
    make_good(8'h05, 7);
    send_frame(1'b0, 1'b0);
    check_result("t5_next", 1'b1);

    make_good(8'h05, 6);
    send_frame(1'b0, 1'b0);
    check_result("f_own", 1'b1);
    make_good(8'hFF, 6);
    send_frame(1'b0, 1'b0);
    check_result("f_bcast", 1'b1);
    make_good(8'h07, 6);
    send_frame(1'b0, 1'b0);
    check_result("f_other", 1'b1);

    make_good(8'h05, 8);
    send_bytes(1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    exp_drops = 0;
    holding = 1'b0;
    repeat (2) @(negedge econet_clk);
    chk("mrst_ready", frame_ready, 0);
    chk("mrst_len", frame_len, 0);
    chk("mrst_flags", {fcs_error, overflow, runt}, 0);
    chk("mrst_drops", drop_count, exp_drops);
    chk("mrst_rdata", rd_data, 0);
    reset = 1'b0;
    send_bytes(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge econet_clk);
    chk("mrst_idle_ready", frame_ready, 0);
    chk("mrst_idle_runt", runt, 0);
    make_good(8'h05, 6);
    send_frame(1'b0, 1'b0);
    check_result("mrst_after", 1'b1);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/econet_rx_frame.md
Name: econet_rx_frame

Overview:
- Parametrised successor to the Econet receive front-end.
- Consumes the byte/frame-delimiter stream from the line deframer.
- Computes CRC-16 (HDLC/X.25) FCS per byte and stores the whole frame in a single-frame buffer.
- At frame end it validates FCS and length, then presents the frame to the host, or discards it, with sticky status.

Parameters:
- DEPTH_LOG2, 9: buffer depth is 2^DEPTH_LOG2 bytes, FCS included.
- MIN_LEN, 6: minimum frame length in bytes, FCS included; shorter frames are runts.
- CNT_W, 8: width of the saturating drop counter.

Ports:
- econet_clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- rx_byte  in  8  received byte.
- rx_byte_ready  in  1  one-cycle strobe; rx_byte valid.
- rx_frame_start  in  1  one-cycle pulse, opening flag seen.
- rx_frame_end  in  1  one-cycle pulse, closing flag seen.
- station_id  in  8  local station number (used by the filter option).
- rd_addr  in  DEPTH_LOG2  host read address.
- rd_data  out  8  buffer byte at rd_addr, registered.
- frame_ready  out  1  a valid frame is held.
- frame_len  out  DEPTH_LOG2+1  payload length, FCS excluded.
- frame_ack  in  1  host releases the held frame.
- fcs_error  out  1  sticky: last frame failed FCS.
- overflow  out  1  sticky: last frame exceeded the buffer.
- runt  out  1  sticky: last frame shorter than MIN_LEN.
- drop_count  out  CNT_W  saturating count of frames lost while a frame was held.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - CRC register 16'hFFFF.
  - Byte count 0.
- CRC: reflected poly 16'h8408, init 16'hFFFF, bytes processed LSB first. A frame including its FCS is good iff the final register equals the residue 16'hF0B8.
- State IDLE:
  - rx_frame_start goes to RECV: clears count, CRC and the sticky flags.
  - Bytes arriving without a start are ignored.
- State RECV:
  - Each rx_byte_ready writes the buffer at the current count, updates the CRC, and increments the count.
  - A strobe while count == 2^DEPTH_LOG2 sets overflow and goes to DISCARD.
  - rx_frame_end goes to CHECK.
  - rx_frame_start restarts the frame: count and CRC are reinitialised and no flag is set.
- Same-cycle events: rx_byte_ready with rx_frame_end in the same cycle stores the byte first, then the end takes effect. rx_frame_start with rx_byte_ready in the same cycle stores that byte as byte 0.
- State CHECK (1 cycle), evaluated in this priority order:
  - count < MIN_LEN: set runt, go to IDLE.
  - CRC != 16'hF0B8: set fcs_error, go to IDLE.
  - Otherwise: frame_len = count - 2, frame_ready = 1, go to HOLD.
- State DISCARD: ignore bytes until rx_frame_end or rx_frame_start, then go to IDLE. A start both leaves DISCARD and opens a new frame, as from IDLE.
- State HOLD:
  - The buffer is frozen and frame_ready stays high.
  - rx_frame_start increments drop_count, saturating at all-ones; that frame is ignored.
  - frame_ack drops frame_ready and goes to IDLE on the next cycle.
  - frame_ack outside HOLD has no effect.
- Read port: rd_data = buf[rd_addr], one-cycle latency, valid in any state. Content is defined only in HOLD for addresses below frame_len + 2.
- drop_count clears only on reset.
- Reset in any state returns to IDLE within one cycle; no frame_ready is issued for a partial frame.

Optional Feature:
- Macro: ECONET_ADDR_FILTER_EN.
- Defined: in CHECK, a frame passing FCS whose byte 0 is neither station_id nor 8'hFF goes to IDLE silently. No flag is set and drop_count is unchanged.
- Undefined: every frame passing FCS and length checks is held; station_id is unused.

Decomposition:
- Shared package:
  - CRC constants: init 16'hFFFF, poly 16'h8408, residue 16'hF0B8.
  - State encoding: IDLE, RECV, CHECK, DISCARD, HOLD.
  - Broadcast id 8'hFF.
- Sub-module econet_crc16: byte-wide combinational next-CRC function plus register, with clear and enable inputs. It is reused by the future transmit block.

Test Plan:
1. Start, then bytes 31 32 33 34 35 36 37 38 39 6E 90, then end -> frame_ready=1, frame_len=9, rd_data at addr 0 = 8'h31, all flags 0.
2. Same frame with last byte 8'h91 -> fcs_error=1, frame_ready=0, state returns to IDLE.
3. Start, 3 bytes, end -> runt=1, frame_ready=0.
4. DEPTH_LOG2=4, start, 17 bytes, end -> overflow=1, frame_ready=0. A following good frame is then accepted.
5. While holding frame 1, send two more good frames -> drop_count=2, and frame 1 content is unchanged. After frame_ack, a fourth frame is accepted.
6. With ECONET_ADDR_FILTER_EN and station_id=8'h05:
   - Good frame with byte0 8'h05 -> held.
   - Byte0 8'hFF -> held.
   - Byte0 8'h07 -> silently dropped, no flags set.
   - Reset asserted mid-frame -> all outputs 0 and state IDLE.
